// File: rtl/prim_arb_rsp_steer.sv
// Steers in-order sink responses back to the arbiter port that issued each request,
// using a small FIFO of winner indices captured on every accepted request.
module prim_arb_rsp_steer #(
    parameter int unsigned N     = 8,
    parameter int unsigned DW    = 32,
    parameter int unsigned Depth = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    input  logic                   req_ready_i,
    input  logic [IdxW-1:0]        req_idx_i,
    output logic                   req_ready_o,
    input  logic                   rsp_valid_i,
    input  logic [DW-1:0]          rsp_data_i,
    output logic                   rsp_ready_o,
    output logic [N-1:0]           rsp_valid_o,
    output logic [N-1:0][DW-1:0]   rsp_data_o,
    input  logic [N-1:0]           rsp_ready_i,
    output logic [CntW-1:0]        outstanding_o,
    output logic                   full_o,
    output logic                   err_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Depth-1:0][IdxW-1:0] mem;
    logic [PtrW-1:0]            wptr;
    logic [PtrW-1:0]            rptr;
    logic [CntW-1:0]            cnt;
    logic                       err_q;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic [IdxW-1:0]            head;
    logic [IdxW-1:0]            wdata;
    logic                       head_ready;

    assign empty = (cnt == '0);
    assign full_o = (cnt == CntW'(Depth));
    assign outstanding_o = cnt;
    assign err_o = err_q;

    // A single-port instance always steers to port 0, whatever the arbiter reports.
    assign wdata = (N == 1) ? '0 : req_idx_i;
    assign head  = (N == 1) ? '0 : mem[rptr];

    assign req_ready_o = req_ready_i & ~full_o;
    assign push        = req_valid_i & req_ready_o;
    assign rsp_ready_o = ~empty & head_ready;
    assign pop         = rsp_valid_i & rsp_ready_o;

    assign rsp_data_o = {N{rsp_data_i}};

    // Decode head index; out-of-range indices select no port.
    always_comb begin
        rsp_valid_o = '0;
        head_ready  = 1'b0;
        for (int unsigned p = 0; p < N; p++) begin
            if (head == IdxW'(p)) begin
                rsp_valid_o[p] = ~empty & rsp_valid_i;
                head_ready     = rsp_ready_i[p];
            end
        end
    end

    // Index FIFO storage, pointers, occupancy and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + PtrW'(1);
            end
            if (pop) begin
                rptr <= rptr + PtrW'(1);
            end
            cnt <= cnt + CntW'(push) - CntW'(pop);
            if (rsp_valid_i && empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
